// File: rtl/instr_encode_loader_if.sv
// Request and memory-write bundle for instr_encode_loader.
// Handshake rules: a request transfers on a rising clk edge where req_vld
// and req_rdy are both high; a memory write completes on an edge where
// im_we and im_rdy are both high. While im_we is high and im_rdy is low,
// im_addr and im_wdata hold their values.
interface instr_encode_loader_if #(
    parameter int ADDR_W = 16
);
    logic              req_vld;
    logic              req_rdy;
    logic [3:0]        op;
    logic [3:0]        fa;
    logic [3:0]        fb;
    logic [11:0]       imm;
    logic              im_we;
    logic              im_rdy;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_wdata;

    modport master (
        output req_vld, op, fa, fb, imm, im_rdy,
        input  req_rdy, im_we, im_addr, im_wdata
    );

    modport slave (
        input  req_vld, op, fa, fb, imm, im_rdy,
        output req_rdy, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs symbolic instruction fields into 16-bit ISA
// words, buffers them in a small FIFO and writes them to instruction memory
// from a programmable base address until a HLT word has been written.
// Define INSTR_ENC_RANGE_CHECK_EN to reject requests whose fields do not fit
// their slots (err_code 01); without it fields are truncated silently.
module instr_encode_loader #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encode_loader_if.slave bus,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]    PTR_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       fifo_mem_q [DEPTH];
    logic [15:0]       fifo_mem_d [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic        active;
    logic [15:0] head;
    logic [15:0] packed_word;
    logic        fields_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        head_is_hlt;
    logic        at_top;

    // FIFO status, handshake outputs and the packed request word.
    always_comb begin
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        active      = (state_q == S_LOAD) || (state_q == S_DRAIN);
        head        = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
        head_is_hlt = (head[15:12] == 4'hF);
        at_top      = &addr_q;

        bus.req_rdy  = (state_q == S_LOAD) && !fifo_full;
        bus.im_we    = active && !fifo_empty;
        bus.im_addr  = addr_q;
        bus.im_wdata = fifo_empty ? 16'h0000 : head;

        if (bus.op <= 4'h9) begin
            packed_word = {bus.op, bus.fa, bus.fb, bus.imm[3:0]};
        end else if (bus.op <= 4'hB) begin
            packed_word = {bus.op, bus.fa, bus.imm[7:0]};
        end else if (bus.op == 4'hC) begin
            packed_word = {bus.op, bus.fa[2:0], bus.imm[8:0]};
        end else if (bus.op == 4'hD) begin
            packed_word = {bus.op, bus.imm};
        end else if (bus.op == 4'hE) begin
            packed_word = {bus.op, 4'h0, bus.fb, 4'h0};
        end else begin
            packed_word = 16'hF000;
        end

`ifdef INSTR_ENC_RANGE_CHECK_EN
        // Each field must fit its slot; the sign-extended forms count as fitting.
        if (bus.op <= 4'h7) begin
            fields_ok = (bus.imm[11:4] == 8'h00);
        end else if (bus.op <= 4'h9) begin
            fields_ok = (bus.imm[11:3] == 9'h000) || (&bus.imm[11:3]);
        end else if (bus.op <= 4'hB) begin
            fields_ok = (bus.imm[11:8] == 4'h0) || (&bus.imm[11:8]);
        end else if (bus.op == 4'hC) begin
            fields_ok = ((bus.imm[11:8] == 4'h0) || (&bus.imm[11:8])) && !bus.fa[3];
        end else begin
            fields_ok = 1'b1;
        end
`else
        fields_ok = 1'b1;
`endif

        accept = bus.req_vld && bus.req_rdy;
        push   = accept && fields_ok;
        pop    = bus.im_we && bus.im_rdy;
    end

    // Next-state logic for the session FSM, FIFO pointers and status.
    always_comb begin
        state_d    = state_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    addr_d     = base_addr;
                    count_d    = '0;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                end
            end
            default: begin
                if (push) begin
                    fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = packed_word;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
                if (accept && !fields_ok) begin
                    err_d = 1'b1;
                    if (err_code_q == 2'b00) err_code_d = 2'b01;
                end
                if (accept && (bus.op == 4'hF)) begin
                    state_d = S_DRAIN;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    count_d  = count_q + CNT_ONE;
                    // The address saturates at the top of the space.
                    if (!at_top) addr_d = addr_q + ADDR_ONE;
                    if (head_is_hlt) begin
                        state_d = S_DONE;
                    end else if (at_top) begin
                        // No room for anything after this word: abandon the session.
                        state_d  = S_DONE;
                        err_d    = 1'b1;
                        if (err_code_d == 2'b00) err_code_d = 2'b10;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    assign count     = count_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign dbg_state = state_q;
endmodule
